// File: rtl/datapath_mc.sv
// Mini SRC datapath: register file, bus, Y/Z/HI/LO/PC/IR/MAR/MDR, single-cycle ALU and a
// multi-cycle signed MUL/DIV engine. Define R0_ZERO_EN to hardwire R[0] to zero.
module datapath_mc #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 4,
   parameter int unsigned C_W    = 19
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  reg_wr_en,
   input  logic [REG_AW-1:0]     reg_wr_sel,
   input  logic [REG_AW-1:0]     reg_rd_sel,
   input  logic [3:0]            bus_sel,
   input  logic                  Yin,
   input  logic                  Zin,
   input  logic                  HIin,
   input  logic                  LOin,
   input  logic                  PCin,
   input  logic                  IRin,
   input  logic                  MARin,
   input  logic                  MDRin,
   input  logic                  Read,
   input  logic [DATA_W-1:0]     Mdatain,
   input  logic [DATA_W-1:0]     InPort,
   input  logic [4:0]            alu_op,
   input  logic                  alu_start,
   output logic                  alu_busy,
   output logic                  alu_done,
   output logic [DATA_W-1:0]     BusMuxOut,
   output logic [DATA_W-1:0]     IR,
   output logic [DATA_W-1:0]     MAR,
   output logic [DATA_W-1:0]     PC,
   output logic [2*DATA_W-1:0]   Z_out
);

   localparam int unsigned NumRegs = 2 ** REG_AW;
   localparam int unsigned ShW     = $clog2(DATA_W);
   localparam logic [ShW-1:0] CntLast = ShW'(DATA_W - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} eng_st_e;

   logic [DATA_W-1:0] regs_q [NumRegs];
   logic [DATA_W-1:0] y_q, zhi_q, zlo_q, hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q;
   logic [DATA_W-1:0] reg_rd, c_ext, alu_res, a_mag, b_mag;
   logic [ShW-1:0]    shamt;
   logic [ShW:0]      shamt_inv;
   logic              reg_wr_ok, start_ok;

   eng_st_e             state_q, state_d;
   logic [ShW-1:0]      cnt_q, cnt_d;
   logic                is_div_q, is_div_d, neg_q, neg_d, negr_q, negr_d, bz_q, bz_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   a_q, a_d, mcand_q, mcand_d;
   logic [2*DATA_W-1:0] acc_q, acc_d, mul_next, div_next, eng_res;
   logic [DATA_W:0]     mul_sum, div_rsh, div_diff;
   logic [DATA_W-1:0]   quo, rem;

`ifdef R0_ZERO_EN
   assign reg_wr_ok = reg_wr_en && (reg_wr_sel != '0);
   assign reg_rd    = (reg_rd_sel == '0) ? '0 : regs_q[reg_rd_sel];
`else
   assign reg_wr_ok = reg_wr_en;
   assign reg_rd    = regs_q[reg_rd_sel];
`endif

   assign c_ext = {{(DATA_W - C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};

   always_comb begin
      BusMuxOut = '0;
      case (bus_sel)
         4'd0:    BusMuxOut = reg_rd;
         4'd1:    BusMuxOut = hi_q;
         4'd2:    BusMuxOut = lo_q;
         4'd3:    BusMuxOut = zhi_q;
         4'd4:    BusMuxOut = zlo_q;
         4'd5:    BusMuxOut = pc_q;
         4'd6:    BusMuxOut = mdr_q;
         4'd7:    BusMuxOut = InPort;
         4'd8:    BusMuxOut = c_ext;
         default: BusMuxOut = '0;
      endcase
   end

   assign shamt     = BusMuxOut[ShW-1:0];
   assign shamt_inv = (ShW+1)'(DATA_W) - {1'b0, shamt};

   always_comb begin
      alu_res = '0;
      case (alu_op)
         5'd0:    alu_res = y_q + BusMuxOut;
         5'd1:    alu_res = y_q - BusMuxOut;
         5'd2:    alu_res = y_q & BusMuxOut;
         5'd3:    alu_res = y_q | BusMuxOut;
         5'd4:    alu_res = y_q >> shamt;
         5'd5:    alu_res = $unsigned($signed(y_q) >>> shamt);
         5'd6:    alu_res = y_q << shamt;
         5'd7:    alu_res = (y_q >> shamt) | (y_q << shamt_inv);
         5'd8:    alu_res = (y_q << shamt) | (y_q >> shamt_inv);
         5'd9:    alu_res = '0 - BusMuxOut;
         5'd10:   alu_res = ~BusMuxOut;
         5'd13:   alu_res = BusMuxOut + 1'b1;
         default: alu_res = '0;
      endcase
   end

   // Engine works on magnitudes; signs are reapplied in StDone.
   assign a_mag    = y_q[DATA_W-1] ? ('0 - y_q) : y_q;
   assign b_mag    = BusMuxOut[DATA_W-1] ? ('0 - BusMuxOut) : BusMuxOut;
   assign start_ok = (state_q == StIdle) && alu_start && (alu_op == 5'd11 || alu_op == 5'd12);

   assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};
   assign div_rsh  = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
   assign div_diff = div_rsh - {1'b0, mcand_q};
   assign div_next = div_diff[DATA_W] ? {div_rsh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                      : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};

   assign quo = acc_q[DATA_W-1:0];
   assign rem = acc_q[2*DATA_W-1:DATA_W];

   always_comb begin
      eng_res = '0;
      if (!is_div_q) begin
         eng_res = neg_q ? ('0 - acc_q) : acc_q;
      end else if (bz_q) begin
         eng_res = {a_q, {DATA_W{1'b1}}};
      end else begin
         eng_res = {(negr_q ? ('0 - rem) : rem), (neg_q ? ('0 - quo) : quo)};
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      negr_d   = negr_q;
      bz_d     = bz_q;
      a_d      = a_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      done_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d  = StRun;
               cnt_d    = '0;
               is_div_d = (alu_op == 5'd12);
               neg_d    = y_q[DATA_W-1] ^ BusMuxOut[DATA_W-1];
               negr_d   = y_q[DATA_W-1];
               bz_d     = (BusMuxOut == '0);
               a_d      = y_q;
               mcand_d  = b_mag;
               acc_d    = {{DATA_W{1'b0}}, a_mag};
            end
         end
         StRun: begin
            acc_d = is_div_q ? div_next : mul_next;
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            done_d  = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         negr_q   <= 1'b0;
         bz_q     <= 1'b0;
         a_q      <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         negr_q   <= negr_d;
         bz_q     <= bz_d;
         a_q      <= a_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         done_q   <= done_d;
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < int'(NumRegs); i++) regs_q[i] <= '0;
      end else if (reg_wr_ok) begin
         regs_q[reg_wr_sel] <= BusMuxOut;
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         y_q   <= '0;
         zhi_q <= '0;
         zlo_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         pc_q  <= '0;
         ir_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
      end else begin
         if (Yin)   y_q   <= BusMuxOut;
         if (HIin)  hi_q  <= BusMuxOut;
         if (LOin)  lo_q  <= BusMuxOut;
         if (PCin)  pc_q  <= BusMuxOut;
         if (IRin)  ir_q  <= BusMuxOut;
         if (MARin) mar_q <= BusMuxOut;
         if (MDRin) mdr_q <= Read ? Mdatain : BusMuxOut;
         // Engine write-back wins; Zin is ignored for the whole busy window.
         if (state_q == StDone) begin
            {zhi_q, zlo_q} <= eng_res;
         end else if (Zin && state_q == StIdle) begin
            zhi_q <= '0;
            zlo_q <= alu_res;
         end
      end
   end

   assign alu_busy = (state_q != StIdle);
   assign alu_done = done_q;
   assign IR       = ir_q;
   assign MAR      = mar_q;
   assign PC       = pc_q;
   assign Z_out    = {zhi_q, zlo_q};

endmodule
